// File: rtl/xor_crc_scheduler_if.sv
// Bundle of the two requester byte streams, the CRC result port and the
// FSM debug view for xor_crc_scheduler.
//
// Handshake: a byte (or result) moves on a rising clk edge where both its
// valid and ready are high. A source holds data/last (or crc/crc_id/crc_err)
// stable until that edge. Dropping valid before the edge has no effect.
interface xor_crc_scheduler_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       req1_ready;
  logic [7:0] crc;
  logic       crc_id;
  logic       crc_err;
  logic       crc_valid;
  logic       crc_ready;
  // FSM state: 0 idle, 1 shift, 2 wait, 3 done
  logic [1:0] dbg_state;

  // Sources and consumer side
  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output crc_ready,
    input  req0_ready, req1_ready,
    input  crc, crc_id, crc_err, crc_valid, dbg_state
  );

  // Scheduler side
  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  crc_ready,
    output req0_ready, req1_ready,
    output crc, crc_id, crc_err, crc_valid, dbg_state
  );
endinterface

// File: rtl/xor_crc_scheduler.sv
// Round-robin scheduler sharing one bit-serial CRC-8 engine between two
// byte-stream requesters. Arbitration is per packet; each accepted byte is
// shifted MSB-first over eight cycles; the final CRC is offered on a
// valid/ready result port tagged with the owning requester.
//
// Optional feature macro: XOR_CRC_SCHED_TIMEOUT_EN
//   defined   - 16 idle cycles in WAIT abort the packet (crc_err=1, partial CRC)
//   undefined - WAIT waits indefinitely, crc_err stays 0
module xor_crc_scheduler #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input logic           clk,
  input logic           rn,
  xor_crc_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t     state;
  logic       owner;
  logic       rr_ptr;
  logic       last_q;
  logic [7:0] crc_q;
  logic [7:0] sh_q;
  logic [2:0] cnt;
  logic       crc_id_q;
  logic       crc_err_q;
  logic       crc_valid_q;

  logic       winner;
  logic       rdy0;
  logic       rdy1;
  logic       xfer;
  logic       sel;
  logic [7:0] in_data;
  logic       in_last;
  logic       fb;
  logic [7:0] crc_next;
  logic       timeout_hit;

  // Ready depends only on state, owner, pointer and the valids
  always_comb begin
    winner = (bus.req0_valid && bus.req1_valid) ? rr_ptr : bus.req1_valid;
    rdy0   = 1'b0;
    rdy1   = 1'b0;
    case (state)
      ST_IDLE: begin
        rdy0 = bus.req0_valid && !winner;
        rdy1 = bus.req1_valid && winner;
      end
      ST_WAIT: begin
        rdy0 = !owner;
        rdy1 = owner;
      end
      default: begin
        rdy0 = 1'b0;
        rdy1 = 1'b0;
      end
    endcase
  end

  assign xfer     = (rdy0 && bus.req0_valid) || (rdy1 && bus.req1_valid);
  assign sel      = (state == ST_IDLE) ? winner : owner;
  assign in_data  = sel ? bus.req1_data : bus.req0_data;
  assign in_last  = sel ? bus.req1_last : bus.req0_last;

  // One step of the XOR-feedback shift register
  assign fb       = crc_q[7] ^ sh_q[7];
  assign crc_next = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);

`ifdef XOR_CRC_SCHED_TIMEOUT_EN
  logic [3:0] idle_cnt;

  assign timeout_hit = (state == ST_WAIT) && !xfer && (idle_cnt == 4'hF);

  // Count consecutive WAIT cycles without an owner byte
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      idle_cnt <= 4'h0;
    end else if (state == ST_WAIT && !xfer) begin
      idle_cnt <= idle_cnt + 4'h1;
    end else begin
      idle_cnt <= 4'h0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Main scheduler FSM with registered result outputs
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      state       <= ST_IDLE;
      owner       <= 1'b0;
      rr_ptr      <= 1'b0;
      last_q      <= 1'b0;
      crc_q       <= 8'h00;
      sh_q        <= 8'h00;
      cnt         <= 3'd0;
      crc_id_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      crc_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            owner  <= winner;
            crc_q  <= INIT;
            sh_q   <= in_data;
            last_q <= in_last;
            cnt    <= 3'd0;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          crc_q <= crc_next;
          sh_q  <= {sh_q[6:0], 1'b0};
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (last_q) begin
              state       <= ST_DONE;
              crc_valid_q <= 1'b1;
              crc_id_q    <= owner;
              crc_err_q   <= 1'b0;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (xfer) begin
            sh_q   <= in_data;
            last_q <= in_last;
            cnt    <= 3'd0;
            state  <= ST_SHIFT;
          end else if (timeout_hit) begin
            state       <= ST_DONE;
            crc_valid_q <= 1'b1;
            crc_id_q    <= owner;
            crc_err_q   <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.crc_ready) begin
            crc_valid_q <= 1'b0;
            rr_ptr      <= ~owner;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.crc        = crc_q;
  assign bus.crc_id     = crc_id_q;
  assign bus.crc_err    = crc_err_q;
  assign bus.crc_valid  = crc_valid_q;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_xor_crc_scheduler.sv
// Bench for xor_crc_scheduler: directed scenarios plus randomized traffic,
// all outputs compared each cycle against a packet-level reference model.
module tb_xor_crc_scheduler;

  localparam logic [7:0] POLY = 8'h07;
  localparam logic [7:0] INIT = 8'h00;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rn  = 1'b0;
  always #5 clk = ~clk;

  xor_crc_scheduler_if bus();
  xor_crc_scheduler #(.POLY(POLY), .INIT(INIT)) dut (.clk(clk), .rn(rn), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- scoreboard ----------------
  // Expected results as {err, id, crc}, head is the one that must be shown.
  logic [9:0] exp_q[$];
  logic       m_ptr, m_owner, m_locked, m_last;
  int         m_shl, m_wcnt;
  logic [7:0] m_crc;
  bit         rand_done = 0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-wise CRC-8 (MSB first, no reflection, no final xor)
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  task automatic model_take(input logic id);
    logic [7:0] d;
    d      = id ? bus.req1_data : bus.req0_data;
    m_last = id ? bus.req1_last : bus.req0_last;
    m_crc  = crc8_byte(m_crc, d);
    m_shl  = 8;
  endtask

  // Compare process: checks every output each cycle, then advances the model
  // by what the coming edge will do with the current (stable) inputs.
  always @(negedge clk) begin : cmp
    logic v0, v1, e0, e1, idle_m;
    logic [9:0] h;
    if (!rn) begin
      exp_q.delete();
      m_ptr = 0; m_owner = 0; m_locked = 0; m_last = 0;
      m_shl = 0; m_wcnt = 0; m_crc = 8'h00;
    end else begin
      v0 = bus.req0_valid;
      v1 = bus.req1_valid;
      idle_m = (exp_q.size() == 0) && (m_shl == 0) && !m_locked;
      e0 = 0;
      e1 = 0;
      if (idle_m) begin
        e0 = v0 && (!v1 || !m_ptr);
        e1 = v1 && (!v0 || m_ptr);
      end else if (m_locked) begin
        e0 = !m_owner;
        e1 = m_owner;
      end
      check8("req0_ready", {7'd0, bus.req0_ready}, {7'd0, e0});
      check8("req1_ready", {7'd0, bus.req1_ready}, {7'd0, e1});
      check8("crc_valid", {7'd0, bus.crc_valid}, {7'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        h = exp_q[0];
        check8("crc", bus.crc, h[7:0]);
        check8("crc_id", {7'd0, bus.crc_id}, {7'd0, h[8]});
        check8("crc_err", {7'd0, bus.crc_err}, {7'd0, h[9]});
      end
      // advance
      if (exp_q.size() != 0) begin
        if (bus.crc_ready) begin
          void'(exp_q.pop_front());
          m_ptr = !m_owner;
        end
      end else if (m_shl > 0) begin
        m_shl--;
        if (m_shl == 0) begin
          if (m_last) exp_q.push_back({1'b0, m_owner, m_crc});
          else begin
            m_locked = 1;
            m_wcnt   = 0;
          end
        end
      end else if (m_locked) begin
        if (m_owner ? v1 : v0) begin
          model_take(m_owner);
          m_locked = 0;
        end
`ifdef XOR_CRC_SCHED_TIMEOUT_EN
        else begin
          m_wcnt++;
          if (m_wcnt == 16) begin
            exp_q.push_back({1'b1, m_owner, m_crc});
            m_locked = 0;
          end
        end
`endif
      end else if (e0 || e1) begin
        m_owner = e1;
        m_crc   = INIT;
        model_take(e1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic id, input logic v, input logic [7:0] d, input logic l);
    if (id) begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_last = l;
    end else begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_last = l;
    end
  endtask

  // Offer one byte until accepted; returns #1 after the accepting edge.
  task automatic send_byte(input logic id, input logic [7:0] d, input logic l, input bit may_drop);
    bit acc = 0;
    bit vld;
    for (int b = 0; b < 600 && !acc; b++) begin
      vld = !(may_drop && $urandom_range(0, 7) == 0);
      drive(id, vld, d, l);
      @(negedge clk);
      acc = vld && (id ? bus.req1_ready : bus.req0_ready);
      @(posedge clk); #1;
    end
    drive(id, 1'b0, d, l);
    check8("send_accept", {7'd0, acc}, 8'd1);
  endtask

  // Count edges until crc_valid is seen (sampled #1 after each edge).
  task automatic wait_valid(output int edges);
    bit seen = 0;
    edges = 0;
    for (int b = 0; b < 200 && !seen; b++) begin
      @(posedge clk); #1;
      edges++;
      seen = bus.crc_valid;
    end
    check8("wait_valid", {7'd0, seen}, 8'd1);
  endtask

  task automatic rand_source(input logic id);
    int len;
    for (int p = 0; p < 6; p++) begin
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        send_byte(id, 8'($urandom), b == len - 1, 1);
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [7:0] s_crc;
    logic       s_id;
    drive(0, 0, 8'h00, 0);
    drive(1, 0, 8'h00, 0);
    bus.crc_ready = 1'b1;

    // model pins
    check8("model_crc_01", crc8_byte(8'h00, 8'h01), 8'h07);
    check8("model_crc_0100", crc8_byte(crc8_byte(8'h00, 8'h01), 8'h00), 8'h15);

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check8("rst_crc", bus.crc, 8'h00);
    check8("rst_valid", {7'd0, bus.crc_valid}, 8'd0);
    check8("rst_state", {6'd0, bus.dbg_state}, 8'd0);
    rn = 1'b1;
    @(posedge clk); #1;

    // REQ0 single byte 0x01
    send_byte(0, 8'h01, 1, 0);
    wait_valid(n);
    check8("single_latency", 8'(n), 8'd8);
    check8("single_crc", bus.crc, 8'h07);
    check8("single_id", {7'd0, bus.crc_id}, 8'd0);
    check8("single_err", {7'd0, bus.crc_err}, 8'd0);
    @(posedge clk); #1;

    // REQ1 packet {0x01, 0x00}
    send_byte(1, 8'h01, 0, 0);
    n = 0;
    for (int b = 0; b < 40; b++) begin
      @(posedge clk); #1;
      n++;
      if (bus.req1_ready) break;
    end
    check8("second_ready_edges", 8'(n), 8'd8);
    send_byte(1, 8'h00, 1, 0);
    wait_valid(n);
    check8("pkt_crc", bus.crc, 8'h15);
    check8("pkt_id", {7'd0, bus.crc_id}, 8'd1);
    @(posedge clk); #1;

    // both continuously valid: alternate 0/1
    drive(0, 1, 8'h00, 1);
    drive(1, 1, 8'h01, 1);
    for (int r = 0; r < 4; r++) begin
      wait_valid(n);
      check8("alt_id", {7'd0, bus.crc_id}, 8'(r % 2));
      check8("alt_crc", bus.crc, (r % 2) ? 8'h07 : 8'h00);
    end
    drive(0, 0, 8'h00, 1);
    drive(1, 0, 8'h01, 1);
    @(posedge clk); #1;

    // backpressure in DONE
    bus.crc_ready = 1'b0;
    send_byte(0, 8'h5A, 1, 0);
    wait_valid(n);
    s_crc = bus.crc;
    s_id  = bus.crc_id;
    check8("bp_crc_model", s_crc, crc8_byte(8'h00, 8'h5A));
    repeat (5) begin
      @(posedge clk); #1;
      check8("bp_crc", bus.crc, s_crc);
      check8("bp_id", {7'd0, bus.crc_id}, {7'd0, s_id});
      check8("bp_valid", {7'd0, bus.crc_valid}, 8'd1);
      check8("bp_ready", {6'd0, bus.req0_ready, bus.req1_ready}, 8'd0);
    end
    bus.crc_ready = 1'b1;
    @(posedge clk); #1;

    // randomized traffic with random consumer backpressure
    fork
      begin
        fork
          rand_source(0);
          rand_source(1);
        join
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          bus.crc_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.crc_ready = 1'b1;
    repeat (30) begin @(posedge clk); #1; end

    // reset mid-SHIFT; pointer left at 1 beforehand
    send_byte(0, 8'h33, 1, 0);
    wait_valid(n);
    @(posedge clk); #1;
    send_byte(0, 8'hC3, 1, 0);
    repeat (3) @(posedge clk);
    #3;
    rn = 1'b0;
    #1;
    check8("arst_crc", bus.crc, 8'h00);
    check8("arst_flags", {4'd0, bus.crc_id, bus.crc_err, bus.crc_valid, 1'b0}, 8'd0);
    check8("arst_ready", {6'd0, bus.req0_ready, bus.req1_ready}, 8'd0);
    @(posedge clk); #1;
    rn = 1'b1;
    drive(0, 1, 8'hAA, 1);
    drive(1, 1, 8'h55, 1);
    wait_valid(n);
    check8("arst_first_id", {7'd0, bus.crc_id}, 8'd0);
    check8("arst_first_crc", bus.crc, crc8_byte(8'h00, 8'hAA));
    drive(0, 0, 8'hAA, 1);
    drive(1, 0, 8'h55, 1);
    repeat (12) begin @(posedge clk); #1; end

    // silent owner in WAIT
    send_byte(0, 8'h01, 0, 0);
`ifdef XOR_CRC_SCHED_TIMEOUT_EN
    wait_valid(n);
    check8("to_latency", 8'(n), 8'd24);
    check8("to_crc", bus.crc, 8'h07);
    check8("to_err", {7'd0, bus.crc_err}, 8'd1);
    check8("to_id", {7'd0, bus.crc_id}, 8'd0);
    @(posedge clk); #1;
`else
    repeat (100) begin @(posedge clk); #1; end
    check8("wait_state", {6'd0, bus.dbg_state}, 8'd2);
    check8("wait_valid_low", {7'd0, bus.crc_valid}, 8'd0);
    send_byte(0, 8'h00, 1, 0);
    wait_valid(n);
    check8("wait_close_crc", bus.crc, 8'h15);
    @(posedge clk); #1;
`endif
    repeat (4) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
